mux4_rr_sched: RTL and testbench
================================

Name: mux4_rr_sched

Overview:
- Round-robin scheduler that shares one 4:1 datapath mux between four requesters and drives its select lines.
- Each requester posts a request and presents data on its mux input. The block grants one requester at a time for a burst of beats.
- The block drives the select pair {s1,s0} and forwards the selected data on a valid/ready output port.
- It sits directly in front of the shared 4:1 mux and owns its select lines.

Parameters:
- DW, 8, data width of each mux input and of y.
- MAX_BEATS, 4, maximum beats per grant before forced release (legal range 1..255).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  per-requester request; req[k] belongs to input ik.
- last  input  4  per-requester last-beat flag; sampled only while that requester is granted.
- i0  input  DW  requester 0 data.
- i1  input  DW  requester 1 data.
- i2  input  DW  requester 2 data.
- i3  input  DW  requester 3 data.
- s0  output  1  mux select LSB (registered).
- s1  output  1  mux select MSB (registered); granted index = {s1,s0}.
- gnt  output  4  one-hot grant (registered); all zero when idle.
- y  output  DW  selected data; combinational mux of i0..i3 by {s1,s0}.
- y_valid  output  1  beat valid.
- y_ready  input  1  downstream accept.
- y_last  output  1  final beat of the current grant.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, gnt=0000, {s1,s0}=00, ptr=3, beat_cnt=0. Consequently y_valid=0, y_last=0, and y=i0.
- A reset asserted mid-burst aborts the burst immediately. No further beats are issued.
- State machine, two states:
  - IDLE: if req!=0, pick the first k with req[k]=1, searching in the order ptr+1, ptr+2, ptr+3, ptr (mod 4). Register gnt=onehot(k), {s1,s0}=k, beat_cnt=0, and go to GRANT. If req=0, stay in IDLE with outputs unchanged.
  - GRANT: sel={s1,s0}.
    - y_valid = req[sel].
    - y_last = y_valid & (last[sel] | beat_cnt==MAX_BEATS-1).
    - A transfer occurs on any cycle with y_valid & y_ready; each transfer increments beat_cnt.
    - Transfer with y_last=1: at the edge, gnt=0000, ptr=sel, go to IDLE. {s1,s0} hold their value.
    - req[sel]=0 (requester withdrew): at the edge, release the same way (gnt=0000, ptr=sel, IDLE). No beat is counted.
    - Otherwise stay in GRANT.
- Latency:
  - req asserted at edge N (IDLE) → gnt and select valid after edge N+1. First beat can transfer in that cycle.
  - There is one IDLE cycle between consecutive grants, so at most one grant per 2 cycles for single-beat bursts.
- Fairness: the last-granted requester has lowest priority at the next arbitration. With all four requesting, the grant order from reset is 0,1,2,3,0,...
- Requests from non-granted requesters are ignored during GRANT. They are never dropped; they are re-evaluated in IDLE.
- y_ready has no effect in IDLE. y_valid never asserts in IDLE.
- With y_valid=1 and y_ready=0, {s1,s0} and y stay stable (req and data must be held stable by the requester).
- beat_cnt is 8 bits wide and never wraps, because the release at MAX_BEATS occurs first.
- gnt is always one-hot or zero, and gnt[k]=1 implies {s1,s0}=k.

Test Plan:
- Reset: apply rst=1 for 2 cycles with req=1111 → gnt=0000, {s1,s0}=00, y_valid=0. Release rst → after the next edge gnt=0001, y=i0.
- Single requester: req=0100, i2=8'hA5, last[2]=1, y_ready=1 → gnt=0100, {s1,s0}=10, y=8'hA5, y_valid=y_last=1 for 1 cycle, then IDLE.
- Round robin: req=1111 held, last=1111, y_ready=1 → grants 0001, 0010, 0100, 1000, 0001 on alternate cycles.
- MAX_BEATS cap: MAX_BEATS=4, req[1]=1, last[1]=0, y_ready=1 → exactly 4 beats. y_last=1 on the 4th beat, then gnt=0000.
- Backpressure: granted requester 3, y_ready=0 for 3 cycles → y_valid=1, y and select stable, beat_cnt unchanged. Then y_ready=1 → transfer.
- Withdraw / reset mid-burst: req[0] drops after 2 beats → release next edge, ptr=0, next grant goes to requester 1 if requesting. rst=1 mid-burst → IDLE, gnt=0000, {s1,s0}=00 after that edge.

Source files
------------

// File: rtl/mux4_rr_sched.sv
// mux4_rr_sched: round-robin owner of a shared 4:1 datapath mux.
//
// Four requesters post requests and present data on their mux inputs. One
// requester at a time is granted for a burst of up to MAX_BEATS beats. The
// block drives the registered select pair {s1,s0} and forwards the selected
// data downstream on a valid/ready port.
//
// Parameters
//   DW         data width of each mux input and of y
//   MAX_BEATS  beats per grant before forced release (1..255)
//
// Ports
//   clk      clock, rising edge
//   rst      synchronous active-high reset
//   req      per-requester request, req[k] belongs to ik
//   last     per-requester last-beat flag, only looked at while granted
//   i0..i3   requester data
//   s0, s1   registered mux select, granted index = {s1,s0}
//   gnt      registered one-hot grant, zero when idle
//   y        selected data, combinational mux of i0..i3 by {s1,s0}
//   y_valid  beat valid
//   y_ready  downstream accept
//   y_last   final beat of the current grant
module mux4_rr_sched #(
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BEATS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    req,
    input  logic [3:0]    last,
    input  logic [DW-1:0] i0,
    input  logic [DW-1:0] i1,
    input  logic [DW-1:0] i2,
    input  logic [DW-1:0] i3,
    output logic          s0,
    output logic          s1,
    output logic [3:0]    gnt,
    output logic [DW-1:0] y,
    output logic          y_valid,
    input  logic          y_ready,
    output logic          y_last
);

    // beat_cnt is 8 bits, so the cap must fit below 256.
    if (MAX_BEATS < 1 || MAX_BEATS > 255) begin : gen_bad_max_beats
        $error("mux4_rr_sched: MAX_BEATS must be in 1..255");
    end

    localparam logic [7:0] LastBeat = 8'(MAX_BEATS - 1);

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;

    // ------------------------------------------------------------------
    // Round-robin pick: search ptr+1, ptr+2, ptr+3, ptr (mod 4). The last
    // granted requester is searched last, which gives it lowest priority.
    // ------------------------------------------------------------------
    logic       arb_found;
    logic [1:0] arb_idx;
    logic [1:0] arb_cand;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = 2'd0;
        arb_cand  = 2'd0;
        for (int unsigned i = 1; i <= 4; i++) begin
            arb_cand = ptr_q + 2'(i);
            if (!arb_found && req[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Beat qualification for the granted requester.
    // ------------------------------------------------------------------
    logic sel_req;
    logic cap_hit;
    logic beat_valid;
    logic beat_last;
    logic beat_xfer;

    always_comb begin
        sel_req    = req[sel_q];
        cap_hit    = (beat_cnt_q == LastBeat);
        beat_valid = (state_q == StGrant) && sel_req;
        beat_last  = beat_valid && (last[sel_q] || cap_hit);
        beat_xfer  = beat_valid && y_ready;
    end

    // ------------------------------------------------------------------
    // State register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            gnt_q      <= 4'b0000;
            sel_q      <= 2'd0;
            ptr_q      <= 2'd3;
            beat_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (arb_found) begin
                    gnt_d      = 4'b0001 << arb_idx;
                    sel_d      = arb_idx;
                    beat_cnt_d = 8'd0;
                    state_d    = StGrant;
                end
            end

            StGrant: begin
                if (!sel_req) begin
                    // Requester withdrew: release without counting a beat.
                    gnt_d   = 4'b0000;
                    ptr_d   = sel_q;
                    state_d = StIdle;
                end else if (beat_xfer) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (beat_last) begin
                        // Select is left as-is so the mux output stays quiet.
                        gnt_d   = 4'b0000;
                        ptr_d   = sel_q;
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs.
    // ------------------------------------------------------------------
    always_comb begin
        s0      = sel_q[0];
        s1      = sel_q[1];
        gnt     = gnt_q;
        y_valid = beat_valid;
        y_last  = beat_last;

        unique case (sel_q)
            2'd0:    y = i0;
            2'd1:    y = i1;
            2'd2:    y = i2;
            2'd3:    y = i3;
            default: y = i0;
        endcase
    end

    // ------------------------------------------------------------------
    // Structural invariants.
    // ------------------------------------------------------------------
    gnt_onehot0_a : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));

    gnt_sel_match_a : assert property (@(posedge clk) disable iff (rst)
        (gnt_q != 4'b0000) |-> gnt_q[sel_q]);

    gnt_state_match_a : assert property (@(posedge clk) disable iff (rst)
        (state_q == StGrant) == (gnt_q != 4'b0000));

    beat_cap_a : assert property (@(posedge clk) disable iff (rst)
        (state_q == StGrant) |-> (beat_cnt_q < 8'(MAX_BEATS)));

    idle_no_valid_a : assert property (@(posedge clk) disable iff (rst)
        (state_q == StIdle) |-> !y_valid);

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Randomized plus directed bench for mux4_rr_sched. A driver applies inputs
// just after each rising edge and runs a behavioural model (integer grant
// owner, pointer and beat count) to queue the expected per-cycle outputs and
// the expected transferred beats. A monitor on the falling edge pops and
// compares against what the DUT presents.
module tb_mux4_rr_sched;

    localparam int unsigned DW        = 8;
    localparam int unsigned MAX_BEATS = 4;

    typedef logic [4*DW-1:0] dat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    req = 4'b0000;
    logic [3:0]    last = 4'b0000;
    logic [DW-1:0] i0 = '0, i1 = '0, i2 = '0, i3 = '0;
    logic          s0, s1;
    logic [3:0]    gnt;
    logic [DW-1:0] y;
    logic          y_valid;
    logic          y_ready = 1'b0;
    logic          y_last;

    always #5 clk = ~clk;

    mux4_rr_sched #(
        .DW        (DW),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .last    (last),
        .i0      (i0),
        .i1      (i1),
        .i2      (i2),
        .i3      (i3),
        .s0      (s0),
        .s1      (s1),
        .gnt     (gnt),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .y_last  (y_last)
    );

    typedef struct packed {
        logic [3:0]    gnt;
        logic [1:0]    sel;
        logic [DW-1:0] y;
        logic          valid;
        logic          last;
    } cyc_t;

    typedef struct packed {
        logic [1:0]    sel;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    cyc_t  cyc_q[$];
    beat_t beat_q[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Behavioural model: who owns the mux (-1 = nobody), where the select
    // points, who was granted last, and how many beats the owner has moved.
    int m_owner = -1;
    int m_sel   = 0;
    int m_prev  = 3;
    int m_beats = 0;
    bit m_known = 1'b0;

    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] lst,
                        input logic rdy, input dat_t d);
        logic [DW-1:0] dv[4];
        cyc_t  c;
        beat_t b;
        bit    v;
        bit    lf;
        @(posedge clk);
        #1;
        rst     = r;
        req     = rq;
        last    = lst;
        y_ready = rdy;
        {i3, i2, i1, i0} = d;
        for (int k = 0; k < 4; k++) dv[k] = d[k*DW +: DW];

        v  = 1'b0;
        lf = 1'b0;
        if (m_owner >= 0) begin
            v  = rq[m_owner];
            lf = v && (lst[m_owner] || (m_beats == int'(MAX_BEATS) - 1));
        end

        if (m_known) begin
            c.gnt   = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
            c.sel   = 2'(m_sel);
            c.y     = dv[m_sel];
            c.valid = v;
            c.last  = lf;
            cyc_q.push_back(c);
            if (v && rdy) begin
                b.sel  = 2'(m_sel);
                b.data = dv[m_sel];
                b.last = lf;
                beat_q.push_back(b);
            end
        end

        // Advance the model to the state after the coming edge.
        if (r) begin
            m_known = 1'b1;
            m_owner = -1;
            m_sel   = 0;
            m_prev  = 3;
            m_beats = 0;
        end else if (m_owner < 0) begin
            for (int j = 1; j <= 4; j++) begin
                if (m_owner < 0 && rq[(m_prev + j) % 4]) begin
                    m_owner = (m_prev + j) % 4;
                end
            end
            if (m_owner >= 0) begin
                m_sel   = m_owner;
                m_beats = 0;
            end
        end else if (!v) begin
            m_prev  = m_owner;
            m_owner = -1;
        end else if (rdy) begin
            m_beats++;
            if (lf) begin
                m_prev  = m_owner;
                m_owner = -1;
            end
        end
    endtask

    function automatic dat_t rd();
        return dat_t'($urandom);
    endfunction

    // Monitor: per-cycle outputs every cycle, beats whenever DUT transfers.
    cyc_t  mc;
    beat_t mb;
    always @(negedge clk) begin
        if (cyc_q.size() > 0) begin
            mc = cyc_q.pop_front();
            check("gnt", 32'(gnt), 32'(mc.gnt));
            check("sel", 32'({s1, s0}), 32'(mc.sel));
            check("y", 32'(y), 32'(mc.y));
            check("y_valid", 32'(y_valid), 32'(mc.valid));
            check("y_last", 32'(y_last), 32'(mc.last));
            if (y_valid === 1'b1 && y_ready === 1'b1) begin
                check("beat_expected", 32'(beat_q.size() != 0), 32'd1);
                if (beat_q.size() != 0) begin
                    mb = beat_q.pop_front();
                    check("beat_sel", 32'({s1, s0}), 32'(mb.sel));
                    check("beat_data", 32'(y), 32'(mb.data));
                    check("beat_last", 32'(y_last), 32'(mb.last));
                end
            end
        end
    end

    logic [3:0] rq_r;
    logic       r_r;

    initial begin
        // Reset held with everyone requesting.
        step(1'b1, 4'b1111, 4'b0000, 1'b1, rd());
        step(1'b1, 4'b1111, 4'b0000, 1'b1, rd());

        // Round robin: single-beat bursts, grants 0,1,2,3,0 on alternate cycles.
        repeat (12) step(1'b0, 4'b1111, 4'b1111, 1'b1, rd());

        // Single requester 2 with data A5.
        step(1'b1, 4'b0000, 4'b0000, 1'b1, rd());
        repeat (4) step(1'b0, 4'b0100, 4'b0100, 1'b1, 32'h11A5_2233);
        step(1'b0, 4'b0000, 4'b0000, 1'b1, rd());

        // MAX_BEATS cap on requester 1.
        step(1'b1, 4'b0000, 4'b0000, 1'b1, rd());
        repeat (12) step(1'b0, 4'b0010, 4'b0000, 1'b1, rd());

        // Backpressure on requester 3, data held.
        step(1'b1, 4'b0000, 4'b0000, 1'b1, rd());
        repeat (4) step(1'b0, 4'b1000, 4'b0000, 1'b0, 32'h5A00_0000);
        step(1'b0, 4'b1000, 4'b1000, 1'b1, 32'h5A00_0000);
        step(1'b0, 4'b0000, 4'b0000, 1'b1, rd());

        // Withdraw after two beats, then requester 1 takes over.
        step(1'b1, 4'b0000, 4'b0000, 1'b1, rd());
        repeat (3) step(1'b0, 4'b0011, 4'b0000, 1'b1, rd());
        repeat (4) step(1'b0, 4'b0010, 4'b0000, 1'b1, rd());

        // Reset mid-burst.
        step(1'b1, 4'b0000, 4'b0000, 1'b1, rd());
        repeat (3) step(1'b0, 4'b0001, 4'b0000, 1'b1, rd());
        step(1'b1, 4'b0001, 4'b0000, 1'b1, rd());
        repeat (3) step(1'b0, 4'b0001, 4'b0000, 1'b1, rd());

        // Randomized traffic with sticky requests.
        rq_r = 4'b0000;
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 5) == 0) rq_r[k] = ~rq_r[k];
            end
            r_r = ($urandom_range(0, 149) == 0);
            step(r_r, rq_r, 4'($urandom) & 4'($urandom), ($urandom_range(0, 3) != 0), rd());
        end

        step(1'b1, 4'b0000, 4'b0000, 1'b0, rd());
        @(posedge clk);
        @(negedge clk);
        #1;
        check("queue_drain", 32'(cyc_q.size() + beat_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
